dram_cmd_responder: RTL

//  Device-side responder for the DRAM command req/ack interface driven by the controller FSM.

---
 rtl/dram_pkg.sv | 27 ++
 rtl/dram_timing_counter.sv | 28 ++
 rtl/dram_cmd_responder.sv | 173 +++++++++++++++++
 3 files changed

// File: rtl/dram_pkg.sv
// Shared definitions for the DRAM command responder: command encodings,
// responder FSM states, default geometry and a small width helper.
package dram_pkg;

    localparam logic [1:0] CMD_ACT = 2'b00;
    localparam logic [1:0] CMD_COL = 2'b01;
    localparam logic [1:0] CMD_REF = 2'b10;
    localparam logic [1:0] CMD_PRE = 2'b11;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        WAIT = 2'b01,
        ACK  = 2'b10
    } resp_state_t;

    localparam int DEF_NUMBER_OF_BANKS = 8;
    localparam int DEF_NUMBER_OF_ROWS  = 128;
    localparam int DEF_NUMBER_OF_COLS  = 8;
    localparam int DEF_BANK_W = $clog2(DEF_NUMBER_OF_BANKS);
    localparam int DEF_ROW_W  = $clog2(DEF_NUMBER_OF_ROWS);
    localparam int DEF_COL_W  = $clog2(DEF_NUMBER_OF_COLS);

    function automatic int max_of(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/dram_timing_counter.sv
// Loadable down-counter with a zero flag; holds at zero until reloaded.
module dram_timing_counter #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [WIDTH-1:0] load_value,
    input  logic             dec,
    output logic [WIDTH-1:0] count,
    output logic             zero
);

    // NOTE: state registers use non-blocking assignments so every flop samples
    // pre-edge values, independent of block evaluation order.
    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
        end else if (load) begin
            count <= load_value;
        end else if (dec && count != '0) begin
            count <= count - 1'b1;
        end
    end

    assign zero = (count == '0);

endmodule

// File: rtl/dram_cmd_responder.sv
// Device-side DRAM command responder: timed ack per command plus per-bank
// open-row tracking. Optional refresh timer: DRAM_RESP_REFRESH_TIMER_EN.
module dram_cmd_responder
    import dram_pkg::*;
#(
    parameter int NUMBER_OF_BANKS  = DEF_NUMBER_OF_BANKS,
    parameter int NUMBER_OF_ROWS   = DEF_NUMBER_OF_ROWS,
    parameter int NUMBER_OF_COLS   = DEF_NUMBER_OF_COLS,
    parameter int T_RCD            = 3,
    parameter int T_CAS            = 2,
    parameter int T_RP             = 3,
    parameter int T_RFC            = 8,
    parameter int REFRESH_INTERVAL = 512
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic                               cmd_req,
    input  logic [1:0]                         cmd,
    input  logic [$clog2(NUMBER_OF_BANKS)-1:0] bank_id,
    input  logic [$clog2(NUMBER_OF_ROWS)-1:0]  row_id,
    input  logic [$clog2(NUMBER_OF_COLS)-1:0]  col_id,
    output logic                               cmd_ack,
    output logic                               cmd_err,
    output logic                               busy,
    output logic [NUMBER_OF_BANKS-1:0]         open_banks,
    output logic [7:0]                         err_count,
    output logic                               refresh_flag,
    output logic [$clog2(NUMBER_OF_ROWS)-1:0]  status_row,
    output logic [$clog2(NUMBER_OF_COLS)-1:0]  status_col
);

    localparam int BANK_W = $clog2(NUMBER_OF_BANKS);
    localparam int ROW_W  = $clog2(NUMBER_OF_ROWS);
    localparam int COL_W  = $clog2(NUMBER_OF_COLS);
    localparam int CNT_W  = $clog2(max_of(max_of(T_RCD, T_CAS), max_of(T_RP, T_RFC)) + 1);

    localparam logic [CNT_W-1:0] LD_RCD = CNT_W'(T_RCD - 1);
    localparam logic [CNT_W-1:0] LD_CAS = CNT_W'(T_CAS - 1);
    localparam logic [CNT_W-1:0] LD_RP  = CNT_W'(T_RP - 1);
    localparam logic [CNT_W-1:0] LD_RFC = CNT_W'(T_RFC - 1);

    if (T_RCD < 1 || T_CAS < 1 || T_RP < 1 || T_RFC < 1) begin : g_bad_timing
        $error("dram_cmd_responder: all timing parameters must be >= 1");
    end
    if (REFRESH_INTERVAL < 2) begin : g_bad_interval
        $error("dram_cmd_responder: REFRESH_INTERVAL must be >= 2");
    end

    resp_state_t       state;
    logic [1:0]        lat_cmd;
    logic [BANK_W-1:0] lat_bank;
    logic [ROW_W-1:0]  lat_row;
    logic [COL_W-1:0]  lat_col;
    logic [ROW_W-1:0]  rows [NUMBER_OF_BANKS];

    logic [CNT_W-1:0] load_value;
    logic [CNT_W-1:0] cnt;
    logic             cnt_zero;
    logic             accept;
    logic             ack_err;

    assign accept = (state == IDLE) && cmd_req;

    // NOTE: default assignment first so no path through the case leaves
    // load_value unassigned and infers a latch.
    always_comb begin
        load_value = LD_RCD;
        case (cmd)
            CMD_COL: load_value = LD_CAS;
            CMD_REF: load_value = LD_RFC;
            CMD_PRE: load_value = LD_RP;
            default: load_value = LD_RCD;
        endcase
    end

    dram_timing_counter #(.WIDTH(CNT_W)) u_timer (
        .clk        (clk),
        .rst        (rst),
        .load       (accept),
        .load_value (load_value),
        .dec        (state == WAIT),
        .count      (cnt),
        .zero       (cnt_zero)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            lat_cmd  <= CMD_ACT;
            lat_bank <= '0;
            lat_row  <= '0;
            lat_col  <= '0;
        end else begin
            case (state)
                IDLE: if (cmd_req) begin
                    lat_cmd  <= cmd;
                    lat_bank <= bank_id;
                    lat_row  <= row_id;
                    lat_col  <= col_id;
                    state    <= WAIT;
                end
                WAIT: if (cnt_zero) state <= ACK;
                ACK:     state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    // Only ACT to an already-open bank and COL to a closed bank are illegal.
    assign ack_err = (state == ACK) &&
                     (((lat_cmd == CMD_ACT) &&  open_banks[lat_bank]) ||
                      ((lat_cmd == CMD_COL) && !open_banks[lat_bank]));

    // NOTE: the row array is small and must read back as 0 after reset, so
    // it is reset explicitly rather than left as an unreset memory.
    always_ff @(posedge clk) begin
        if (rst) begin
            open_banks <= '0;
            for (int b = 0; b < NUMBER_OF_BANKS; b++) rows[b] <= '0;
        end else if (state == ACK) begin
            case (lat_cmd)
                CMD_ACT: if (!open_banks[lat_bank]) begin
                    open_banks[lat_bank] <= 1'b1;
                    rows[lat_bank]       <= lat_row;
                end
                CMD_PRE: open_banks[lat_bank] <= 1'b0;
                CMD_REF: open_banks <= '0;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            err_count <= 8'h00;
        end else if (ack_err && err_count != 8'hFF) begin
            err_count <= err_count + 8'd1;
        end
    end

    assign cmd_ack    = (state == ACK);
    assign cmd_err    = ack_err;
    assign busy       = (state != IDLE);
    assign status_row = rows[lat_bank];
    assign status_col = lat_col;

`ifdef DRAM_RESP_REFRESH_TIMER_EN
    localparam int RI_W = $clog2(REFRESH_INTERVAL);
    localparam logic [RI_W-1:0] REF_LAST = RI_W'(REFRESH_INTERVAL - 1);

    logic [RI_W-1:0] ref_cnt;
    logic            ref_pending;
    logic            ref_ack;

    assign ref_ack = (state == ACK) && (lat_cmd == CMD_REF);

    always_ff @(posedge clk) begin
        if (rst || ref_ack) begin
            ref_cnt     <= '0;
            ref_pending <= 1'b0;
        end else begin
            ref_cnt <= (ref_cnt == REF_LAST) ? '0 : ref_cnt + 1'b1;
            if (ref_cnt == REF_LAST) ref_pending <= 1'b1;
        end
    end

    // Flag is visible in the cycle the count reaches the interval end.
    assign refresh_flag = ref_pending || (ref_cnt == REF_LAST);
`else
    assign refresh_flag = 1'b0;
`endif

endmodule
